act_tanh_div: RTL and testbench

Sequential activation stage sitting directly downstream of the CORDIC sinh/cosh pipeline. It consumes each (sinh, cosh) Q16.16 pair on `pre_vaild` and computes tanh = sinh/cosh with a radix-2 restoring divider. Optionally it post-processes the result to sigmoid = (1 + tanh)/2, which is valid when upstream was fed alpha/2. A small input FIFO absorbs back-to-back CORDIC results, because the upstream pipeline has no backpressure.

---
 rtl/act_pkg.sv | 7 +
 rtl/act_sync_fifo.sv | 43 ++++
 rtl/act_tanh_div.sv | 146 ++++++++++++++
 tb/tb_act_tanh_div.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/act_pkg.sv
// Shared constants and FSM state type for the tanh/sigmoid divider stage.
package act_pkg;
  localparam int ONE       = 65536;  // 1.0 in Q16.16
  localparam int QW        = 17;     // quotient width, saturated value is 1<<16
  localparam int DIV_ITERS = 17;     // one quotient bit per DIV cycle
  typedef enum logic [1:0] {IDLE, DIV, OUT} state_t;
endpackage

// File: rtl/act_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; full/empty derived from registered pointers.
module act_sync_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Status and read data come straight from the registered pointers.
  always_comb begin
    empty = (wr_ptr == rd_ptr);
    full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    dout  = mem[rd_ptr[AW-1:0]];
  end

  // Pointer update; push/pop are already qualified by the caller.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; no reset needed on the data array.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/act_tanh_div.sv
// tanh = sinh/cosh via 17-step restoring divider, optional sigmoid = (1+tanh)/2.
module act_tanh_div #(
  parameter int FIFO_DEPTH = 4,
  parameter int FRAC       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [31:0] sinh,
  input  logic signed [31:0] cosh,
  input  logic               act_sel,
  input  logic               pre_vaild,
  output logic signed [31:0] act_out,
  output logic               post_vaild,
  output logic               busy,
  output logic               ovf,
  output logic               div_err
);
  import act_pkg::*;

  localparam int FW = 65;

  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic [FW-1:0] fifo_dout;

  logic signed [31:0] in_sinh;
  logic signed [31:0] in_cosh;
  logic               in_sel;
  logic [31:0]        abs_in;
  logic               sat_in;

  state_t         state;
  logic           sign_q;
  logic           sel_q;
  logic           sat_q;
  logic [31:0]    cosh_q;
  logic [47:0]    rem_q;
  logic [QW-1:0]  quot_q;
  logic [4:0]     cnt_q;

  logic [47:0]        shifted;
  logic [48:0]        trial;
  logic signed [31:0] q_s;
  logic signed [31:0] sum_s;
  logic signed [31:0] sig_s;

  act_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   ({sinh, cosh, act_sel}),
    .full  (fifo_full),
    .empty (fifo_empty),
    .dout  (fifo_dout)
  );

  // FIFO handshake: a full FIFO still accepts a push when IDLE pops in the same cycle.
  always_comb begin
    pop  = (state == IDLE) && !fifo_empty;
    push = pre_vaild && (!fifo_full || pop);
    busy = (state != IDLE) || !fifo_empty;
  end

  // Unpack the head entry, take |sinh| (clamping -2^31) and detect saturation.
  always_comb begin
    in_sinh = fifo_dout[64:33];
    in_cosh = fifo_dout[32:1];
    in_sel  = fifo_dout[0];
    if (!in_sinh[31])                   abs_in = in_sinh;
    else if (in_sinh == 32'h8000_0000)  abs_in = 32'h7FFF_FFFF;
    else                                abs_in = -in_sinh;
    sat_in = (in_cosh <= 32'sd0) || (abs_in >= $unsigned(in_cosh));
  end

  // Restoring-divider trial subtraction for the current quotient bit.
  always_comb begin
    shifted = 48'(cosh_q) << cnt_q;
    trial   = {1'b0, rem_q} - {1'b0, shifted};
  end

  // Apply the sign, then optionally map tanh to sigmoid.
  always_comb begin
    q_s   = sign_q ? -$signed({15'b0, quot_q}) : $signed({15'b0, quot_q});
    sum_s = q_s + ONE;
    sig_s = sum_s >>> 1;
  end

  // Control FSM plus datapath registers and output flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sign_q     <= 1'b0;
      sel_q      <= 1'b0;
      sat_q      <= 1'b0;
      cosh_q     <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      cnt_q      <= '0;
      act_out    <= '0;
      post_vaild <= 1'b0;
      div_err    <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      post_vaild <= 1'b0;
      div_err    <= 1'b0;
      if (pre_vaild && !push) ovf <= 1'b1;
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            sign_q <= in_sinh[31];
            sel_q  <= in_sel;
            sat_q  <= sat_in;
            cosh_q <= in_cosh;
            rem_q  <= 48'(abs_in) << FRAC;
            // Saturated samples still walk all DIV cycles with the quotient
            // frozen at 1.0, so every result has the same latency.
            quot_q <= sat_in ? QW'(ONE) : '0;
            cnt_q  <= 5'(DIV_ITERS - 1);
            state  <= DIV;
          end
        end
        DIV: begin
          if (!sat_q && !trial[48]) begin
            rem_q         <= trial[47:0];
            quot_q[cnt_q] <= 1'b1;
          end
          if (cnt_q == '0) state <= OUT;
          else             cnt_q <= cnt_q - 1'b1;
        end
        OUT: begin
          act_out    <= sel_q ? sig_s : q_s;
          post_vaild <= 1'b1;
          div_err    <= sat_q;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_act_tanh_div.sv
// Self-checking bench for act_tanh_div against an arithmetic reference model.
module tb_act_tanh_div;
  logic               clk = 1'b0;
  logic               rst;
  logic signed [31:0] sinh;
  logic signed [31:0] cosh;
  logic               act_sel;
  logic               pre_vaild;
  logic signed [31:0] act_out;
  logic               post_vaild;
  logic               busy;
  logic               ovf;
  logic               div_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic signed [31:0] s;
    logic signed [31:0] c;
    logic               sel;
  } vec_t;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  act_tanh_div #(
    .FIFO_DEPTH (4),
    .FRAC       (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sinh       (sinh),
    .cosh       (cosh),
    .act_sel    (act_sel),
    .pre_vaild  (pre_vaild),
    .act_out    (act_out),
    .post_vaild (post_vaild),
    .busy       (busy),
    .ovf        (ovf),
    .div_err    (div_err)
  );

  // Reference: truncated (|s|*2^16)/c, saturating to 1.0 when c<=0 or |s|>=c.
  function automatic longint ref_out(input vec_t v, output bit sat);
    longint s;
    longint c;
    longint a;
    longint q;
    s = longint'(v.s);
    c = longint'(v.c);
    a = (s < 0) ? -s : s;
    if (a > 64'sd2147483647) a = 64'sd2147483647;
    sat = (c <= 0) || (a >= c);
    q = sat ? 64'sd65536 : (a * 65536) / c;
    if (s < 0) q = -q;
    return v.sel ? (q + 65536) / 2 : q;
  endfunction

  task automatic gen(output vec_t v);
    int unsigned c;
    int unsigned m;
    int unsigned mode;
    c    = $urandom_range(32'd65536, 32'd16777216);
    mode = $urandom_range(0, 9);
    v.sel = 1'($urandom_range(0, 1));
    v.c   = $signed(c);
    if (mode == 0) begin
      v.c = -$signed($urandom_range(0, 1000));
      v.s = $signed($urandom_range(0, 100000));
    end else if (mode == 1) begin
      v.s = ($urandom_range(0, 1) != 0) ? $signed(c) : -$signed(c);
    end else if (mode == 2) begin
      v.s = 32'sh8000_0000;
    end else begin
      m   = $urandom_range(0, c - 1);
      v.s = ($urandom_range(0, 1) != 0) ? -$signed(m) : $signed(m);
    end
  endtask

  task automatic drive(input vec_t v);
    sinh      = v.s;
    cosh      = v.c;
    act_sel   = v.sel;
    pre_vaild = 1'b1;
  endtask

  task automatic wait_post(input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(posedge clk);
      #1;
      if (post_vaild) seen = 1'b1;
    end
  endtask

  task automatic apply_reset();
    rst       = 1'b1;
    pre_vaild = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    pre_vaild = 1'b0;
    sinh      = '0;
    cosh      = '0;
    act_sel   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (act_out !== 32'sd0) begin errors++; $display("FAIL reset_act_out: got %0d expected 0", act_out); end
    checks++; if (post_vaild !== 1'b0) begin errors++; $display("FAIL reset_post_vaild: got %b expected 0", post_vaild); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
    checks++; if (div_err !== 1'b0) begin errors++; $display("FAIL reset_div_err: got %b expected 0", div_err); end
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0 || post_vaild !== 1'b0) begin errors++; $display("FAIL idle_after_reset: busy %b post_vaild %b expected 0 0", busy, post_vaild); end
  endtask

  task automatic test_directed();
    vec_t            tv[8];
    int              exp_v[8];
    bit              exp_e[8];
    int              e0;
    bit              seen;
    tv[0] = '{32'sd34151,  32'sd73900, 1'b0}; exp_v[0] = 30285;  exp_e[0] = 1'b0;
    tv[1] = '{-32'sd34151, 32'sd73900, 1'b0}; exp_v[1] = -30285; exp_e[1] = 1'b0;
    tv[2] = '{-32'sd34151, 32'sd73900, 1'b1}; exp_v[2] = 17625;  exp_e[2] = 1'b0;
    tv[3] = '{32'sd0,      32'sd65536, 1'b0}; exp_v[3] = 0;      exp_e[3] = 1'b0;
    tv[4] = '{32'sd0,      32'sd65536, 1'b1}; exp_v[4] = 32768;  exp_e[4] = 1'b0;
    tv[5] = '{32'sd1000,   32'sd0,     1'b0}; exp_v[5] = 65536;  exp_e[5] = 1'b1;
    tv[6] = '{-32'sd80000, 32'sd70000, 1'b0}; exp_v[6] = -65536; exp_e[6] = 1'b1;
    tv[7] = '{32'sh8000_0000, 32'sd65536, 1'b1}; exp_v[7] = 0;   exp_e[7] = 1'b1;
    foreach (tv[k]) begin
      drive(tv[k]);
      @(posedge clk);
      #1;
      e0 = cyc;
      pre_vaild = 1'b0;
      wait_post(40, seen);
      checks++;
      if (!seen) begin
        errors++; $display("FAIL dir_timeout[%0d]: no post_vaild within 40 cycles", k);
      end else begin
        if (cyc - e0 !== 19) begin errors++; $display("FAIL dir_latency[%0d]: got %0d expected 19", k, cyc - e0); end
        checks++; if (act_out !== exp_v[k]) begin errors++; $display("FAIL dir_value[%0d]: got %0d expected %0d", k, act_out, exp_v[k]); end
        checks++; if (div_err !== exp_e[k]) begin errors++; $display("FAIL dir_div_err[%0d]: got %b expected %b", k, div_err, exp_e[k]); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dir_busy[%0d]: got %b expected 0", k, busy); end
        @(posedge clk);
        #1;
        checks++; if (post_vaild !== 1'b0 || div_err !== 1'b0) begin errors++; $display("FAIL dir_pulse[%0d]: post_vaild %b div_err %b expected 0 0", k, post_vaild, div_err); end
        checks++; if (act_out !== exp_v[k]) begin errors++; $display("FAIL dir_hold[%0d]: got %0d expected %0d", k, act_out, exp_v[k]); end
      end
    end
  endtask

  task automatic test_random();
    vec_t   v;
    longint exp_v;
    bit     exp_e;
    int     e0;
    bit     seen;
    for (int k = 0; k < 24; k++) begin
      gen(v);
      exp_v = ref_out(v, exp_e);
      drive(v);
      @(posedge clk);
      #1;
      e0 = cyc;
      pre_vaild = 1'b0;
      wait_post(40, seen);
      checks++;
      if (!seen) begin
        errors++; $display("FAIL rnd_timeout[%0d]: no post_vaild within 40 cycles", k);
      end else begin
        if (cyc - e0 !== 19) begin errors++; $display("FAIL rnd_latency[%0d]: got %0d expected 19", k, cyc - e0); end
        checks++; if (longint'(act_out) !== exp_v) begin errors++; $display("FAIL rnd_value[%0d]: s=%0d c=%0d sel=%b got %0d expected %0d", k, v.s, v.c, v.sel, act_out, exp_v); end
        checks++; if (div_err !== exp_e) begin errors++; $display("FAIL rnd_div_err[%0d]: got %b expected %b", k, div_err, exp_e); end
      end
    end
  endtask

  task automatic test_burst();
    vec_t   v;
    longint exp_q[$];
    bit     err_q[$];
    longint ev;
    bit     ee;
    int     e0;
    bit     seen;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      gen(v);
      ev = ref_out(v, ee);
      if (i < 5) begin exp_q.push_back(ev); err_q.push_back(ee); end
      drive(v);
      @(posedge clk);
      #1;
      if (i == 0) e0 = cyc;
    end
    pre_vaild = 1'b0;
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL burst_ovf: got %b expected 1", ovf); end
    for (int k = 0; k < 5; k++) begin
      wait_post(40, seen);
      checks++;
      if (!seen) begin
        errors++; $display("FAIL burst_timeout[%0d]: no post_vaild within 40 cycles", k);
      end else begin
        if (cyc - e0 !== 19 * (k + 1)) begin errors++; $display("FAIL burst_timing[%0d]: got %0d expected %0d", k, cyc - e0, 19 * (k + 1)); end
        ev = exp_q.pop_front();
        ee = err_q.pop_front();
        checks++; if (longint'(act_out) !== ev) begin errors++; $display("FAIL burst_value[%0d]: got %0d expected %0d", k, act_out, ev); end
        checks++; if (div_err !== ee) begin errors++; $display("FAIL burst_div_err[%0d]: got %b expected %b", k, div_err, ee); end
      end
    end
    wait_post(45, seen);
    checks++; if (seen) begin errors++; $display("FAIL burst_extra_output: got post_vaild expected none"); end
    checks++; if (ovf !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL burst_final: ovf %b busy %b expected 1 0", ovf, busy); end
  endtask

  task automatic test_full_push_pop();
    vec_t   v;
    longint exp_q[$];
    longint ev;
    bit     ee;
    int     e0;
    bit     seen;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      gen(v);
      exp_q.push_back(ref_out(v, ee));
      drive(v);
      @(posedge clk);
      #1;
      if (i == 0) e0 = cyc;
    end
    pre_vaild = 1'b0;
    wait_post(40, seen);
    checks++;
    if (!seen) begin
      errors++; $display("FAIL fpp_first_timeout: no post_vaild within 40 cycles");
    end else begin
      if (cyc - e0 !== 19) begin errors++; $display("FAIL fpp_first_latency: got %0d expected 19", cyc - e0); end
      ev = exp_q.pop_front();
      checks++; if (longint'(act_out) !== ev) begin errors++; $display("FAIL fpp_first_value: got %0d expected %0d", act_out, ev); end
      // The next edge is an IDLE pop with the FIFO full: push the sixth sample there.
      gen(v);
      exp_q.push_back(ref_out(v, ee));
      drive(v);
      @(posedge clk);
      #1;
      pre_vaild = 1'b0;
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL fpp_ovf: got %b expected 0", ovf); end
      for (int k = 0; k < 5; k++) begin
        wait_post(40, seen);
        checks++;
        if (!seen) begin
          errors++; $display("FAIL fpp_timeout[%0d]: no post_vaild within 40 cycles", k);
        end else begin
          ev = exp_q.pop_front();
          checks++; if (longint'(act_out) !== ev) begin errors++; $display("FAIL fpp_value[%0d]: got %0d expected %0d", k, act_out, ev); end
        end
      end
      checks++; if (ovf !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL fpp_final: ovf %b busy %b expected 0 0", ovf, busy); end
    end
  endtask

  task automatic test_reset_mid();
    vec_t   v;
    longint ev;
    bit     ee;
    int     e0;
    bit     seen;
    apply_reset();
    v = '{32'sd34151, 32'sd73900, 1'b0};
    drive(v);
    @(posedge clk);
    #1;
    pre_vaild = 1'b0;
    wait_post(40, seen);
    checks++; if (!seen || act_out !== 32'sd30285) begin errors++; $display("FAIL rmid_prefill: seen %b got %0d expected 30285", seen, act_out); end
    v = '{-32'sd34151, 32'sd73900, 1'b1};
    drive(v);
    @(posedge clk);
    #1;
    v = '{32'sd1000, 32'sd0, 1'b0};
    drive(v);
    @(posedge clk);
    #1;
    pre_vaild = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++; if (act_out !== 32'sd0) begin errors++; $display("FAIL rmid_act_out: got %0d expected 0", act_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b expected 0", busy); end
    checks++; if (post_vaild !== 1'b0 || div_err !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL rmid_flags: post_vaild %b div_err %b ovf %b expected 0 0 0", post_vaild, div_err, ovf); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_post(40, seen);
    checks++; if (seen) begin errors++; $display("FAIL rmid_ghost_output: got post_vaild expected none"); end
    v = '{-32'sd80000, 32'sd70000, 1'b1};
    ev = ref_out(v, ee);
    drive(v);
    @(posedge clk);
    #1;
    e0 = cyc;
    pre_vaild = 1'b0;
    wait_post(40, seen);
    checks++;
    if (!seen) begin
      errors++; $display("FAIL rmid_after_timeout: no post_vaild within 40 cycles");
    end else begin
      if (cyc - e0 !== 19) begin errors++; $display("FAIL rmid_after_latency: got %0d expected 19", cyc - e0); end
      checks++; if (longint'(act_out) !== ev || div_err !== ee) begin errors++; $display("FAIL rmid_after_value: got %0d/%b expected %0d/%b", act_out, div_err, ev, ee); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_burst();
    test_full_push_pop();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
